// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
// Port ids, command payload and a port-to-one-hot helper.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NPORT      = 2;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_e;

    // Command payload at the default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic                  valid;
        port_e                 port;
        logic                  wr;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

    function automatic logic [NPORT-1:0] port_onehot(input port_e p);
        return (p == PORT_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Round-robin grant with per-requester lock for two RAM requesters.
// Grant is combinational; pointer and lock owner advance only on accepted transfers.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] lock,
    output logic [NPORT-1:0] gnt_c
);

    port_e            ptr_q;
    port_e            own_q;
    logic             own_v_q;
    logic             held_c;
    logic [NPORT-1:0] acc_c;

    // Owner keeps the grant only while it still requests with lock high.
    always_comb begin
        gnt_c  = '0;
        held_c = own_v_q && req[own_q] && lock[own_q];
        if (!rst_n) begin
            gnt_c = '0;
        end else if (held_c) begin
            gnt_c = port_onehot(own_q);
        end else if (req == 2'b11) begin
            gnt_c = port_onehot(ptr_q);
        end else begin
            gnt_c = req;
        end
    end

    assign acc_c = req & gnt_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= PORT_CPU;
            own_q   <= PORT_CPU;
            own_v_q <= 1'b0;
        end else if (|acc_c) begin
            ptr_q   <= acc_c[1] ? PORT_CPU : PORT_LDR;
            own_q   <= acc_c[1] ? PORT_LDR : PORT_CPU;
            own_v_q <= |(acc_c & lock);
        end else begin
            own_v_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with a two-stage pipeline:
// accept -> command register -> RAM access / read capture -> response pulse.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORT-1:0]      req,
    input  logic [NPORT-1:0]      lock,
    input  logic [NPORT-1:0]      wr,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [NPORT-1:0]      gnt,
    output logic [NPORT-1:0]      rsp_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     ram_a,
    output logic [DATA_W-1:0]     ram_wd,
    output logic                  ram_we,
    input  logic [DATA_W-1:0]     ram_rd
);

    typedef struct packed {
        logic              valid;
        port_e             port;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_w_t;

    cmd_w_t cmd_q;
    cmd_w_t cmd_nxt_c;
    logic   acc_any_c;

    ram_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .lock  (lock),
        .gnt_c (gnt)
    );

    // Payload fields only load on accept so the RAM address/data hold when idle.
    always_comb begin
        acc_any_c       = |(req & gnt);
        cmd_nxt_c       = cmd_q;
        cmd_nxt_c.valid = acc_any_c;
        if (acc_any_c) begin
            cmd_nxt_c.port  = gnt[1] ? PORT_LDR : PORT_CPU;
            cmd_nxt_c.wr    = gnt[1] ? wr[1] : wr[0];
            cmd_nxt_c.addr  = gnt[1] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            cmd_nxt_c.wdata = gnt[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        end
    end

    // Stage 1: command register; ram_we is a dedicated flop mirroring valid && wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= '0;
            ram_we <= 1'b0;
        end else begin
            cmd_q  <= cmd_nxt_c;
            ram_we <= cmd_nxt_c.valid && cmd_nxt_c.wr;
        end
    end

    assign ram_a  = cmd_q.addr;
    assign ram_wd = cmd_q.wdata;

    // Stage 2: capture read data and raise the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rdata     <= '0;
        end else begin
            rsp_valid <= cmd_q.valid ? port_onehot(cmd_q.port) : '0;
            if (cmd_q.valid && !cmd_q.wr) begin
                rdata <= ram_rd;
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_req:    assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req) == 2'b00);
    a_we_cmd:     assert property (@(posedge clk) disable iff (!rst_n)
                                   ram_we == (cmd_q.valid && cmd_q.wr));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed stimulus, a transaction-level model with a
// per-cycle compare on the falling edge, and literal expectations per scenario.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, lock, wr;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt, rsp_valid;
    logic [31:0] rdata, ram_a, ram_wd, ram_rd;
    logic        ram_we;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .ram_a     (ram_a),
        .ram_wd    (ram_wd),
        .ram_we    (ram_we),
        .ram_rd    (ram_rd)
    );

    // External RAM: synchronous write, combinational read.
    bit [31:0] mem [64];
    assign ram_rd = mem[ram_a[7:2]];
    always @(posedge clk) if (ram_we) mem[ram_a[7:2]] <= ram_wd;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int          tag;
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ent_t;

    ent_t        q[$];
    bit [31:0]   refmem [64];
    int          cyc;
    bit          last_p;
    bit          own_v;
    bit          own_p;
    bit          pend_we;
    logic [31:0] pend_a, pend_d;
    logic [31:0] last_a, last_d, e_rdata;

    function automatic void model_reset();
        q.delete();
        pend_we = 1'b0;
        last_p  = 1'b1;
        own_v   = 1'b0;
        own_p   = 1'b0;
        last_a  = '0;
        last_d  = '0;
        e_rdata = '0;
    endfunction

    always @(negedge clk) begin
        bit          gv, gp, held;
        logic [1:0]  g, e_rsp;
        logic        e_we;
        cyc++;
        if (!rst_n) begin
            chk("rst_gnt",   64'(gnt),       64'(0));
            chk("rst_we",    64'(ram_we),    64'(0));
            chk("rst_rsp",   64'(rsp_valid), 64'(0));
            chk("rst_rdata", 64'(rdata),     64'(0));
            chk("rst_ram_a", 64'(ram_a),     64'(0));
            chk("rst_ramwd", 64'(ram_wd),    64'(0));
        end else begin
            if (pend_we) begin
                refmem[pend_a[7:2]] = pend_d;
                pend_we = 1'b0;
            end
            // Grant rule: locked owner, else the one not served last, else whoever asks.
            held = own_v && req[own_p] && lock[own_p];
            gv = 1'b1;
            gp = 1'b0;
            if (held)                gp = own_p;
            else if (req == 2'b11)   gp = ~last_p;
            else if (req[0])         gp = 1'b0;
            else if (req[1])         gp = 1'b1;
            else                     gv = 1'b0;
            g = gv ? (gp ? 2'b10 : 2'b01) : 2'b00;

            e_we  = 1'b0;
            e_rsp = 2'b00;
            foreach (q[i]) begin
                if (q[i].tag == cyc - 1) begin
                    e_we   = q[i].wr;
                    last_a = q[i].addr;
                    last_d = q[i].wdata;
                    if (q[i].wr) begin
                        pend_we = 1'b1;
                        pend_a  = q[i].addr;
                        pend_d  = q[i].wdata;
                    end else begin
                        q[i].rdata = refmem[q[i].addr[7:2]];
                    end
                end
                if (q[i].tag == cyc - 2) begin
                    e_rsp[q[i].port] = 1'b1;
                    if (!q[i].wr) e_rdata = q[i].rdata;
                end
            end
            while (q.size() > 0 && q[0].tag <= cyc - 2) void'(q.pop_front());

            chk("gnt",       64'(gnt),       64'(g));
            chk("ram_we",    64'(ram_we),    64'(e_we));
            chk("ram_a",     64'(ram_a),     64'(last_a));
            chk("ram_wd",    64'(ram_wd),    64'(last_d));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
            chk("rdata",     64'(rdata),     64'(e_rdata));

            if (gv) begin
                q.push_back('{tag: cyc, port: gp, wr: wr[gp],
                              addr:  gp ? addr[63:32]  : addr[31:0],
                              wdata: gp ? wdata[63:32] : wdata[31:0],
                              rdata: 32'h0});
                last_p = gp;
                own_v  = lock[gp];
                own_p  = gp;
            end else begin
                own_v = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] gs;
    logic [1:0] gseq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    task automatic step(input logic [1:0] r, input logic [1:0] lk, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        req   = r;
        lock  = lk;
        wr    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        #1 gs = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        rst_n = 1'b0; req = '0; lock = '0; wr = '0; addr = '0; wdata = '0;
        model_reset();
        @(posedge clk);
        #1 req = 2'b11;
        #1;
        chk("lit_rst_gnt",   64'(gnt),       64'(0));
        chk("lit_rst_we",    64'(ram_we),    64'(0));
        chk("lit_rst_rsp",   64'(rsp_valid), 64'(0));
        chk("lit_rst_rdata", 64'(rdata),     64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = '0;

        // Reset mid-write to 0x4: write must be dropped.
        step(2'b01, 2'b00, 2'b01, 32'h4, 32'h0, 32'h55, 32'h0);
        chk("lit_first_gnt", 64'(gs), 64'(2'b01));
        req = '0; wr = '0;
        @(negedge clk);
        #1;
        chk("lit_we_inflight", 64'(ram_we), 64'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("lit_we_drop",  64'(ram_we),    64'(0));
        chk("lit_rsp_drop", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        chk("lit_no_rsp_after_rst", 64'(rsp_valid), 64'(0));
        idle();
        step(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0);
        idle();
        chk("lit_rd4_old_rsp",   64'(rsp_valid), 64'(2'b01));
        chk("lit_rd4_old_rdata", 64'(rdata),     64'(32'h0));

        // Single port write then read.
        step(2'b01, 2'b00, 2'b01, 32'h4, 32'h0, 32'h100, 32'h0);
        step(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0);
        chk("lit_wr_rsp", 64'(rsp_valid), 64'(2'b01));
        idle();
        chk("lit_rd_rsp",   64'(rsp_valid), 64'(2'b01));
        chk("lit_rd_rdata", 64'(rdata),     64'(32'h100));

        // Contention: port 1 served last, so port 0 leads the alternation.
        idle();
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h8, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, 2'b00, 32'h4, 32'h8, 32'h0, 32'h0);
            chk($sformatf("lit_rr_gnt%0d", i), 64'(gs), 64'(gseq[i]));
            if (i >= 1) chk($sformatf("lit_rr_rsp%0d", i), 64'(rsp_valid), 64'(gseq[i-1]));
        end

        // Lock: port 0 served last so port 1 wins, then holds for 4 writes.
        step(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b10, 2'b10, 32'h4, 32'(32'h10 + 4 * i), 32'h0, 32'(32'hA0 + i));
            chk($sformatf("lit_lock_gnt%0d", i), 64'(gs), 64'(2'b10));
        end
        step(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0);
        chk("lit_lock_release", 64'(gs), 64'(2'b01));
        idle();
        step(2'b01, 2'b00, 2'b00, 32'h1C, 32'h0, 32'h0, 32'h0);
        idle();
        chk("lit_lock_rd1c", 64'(rdata), 64'(32'hA3));

        // Read-after-write across ports in consecutive cycles.
        step(2'b10, 2'b00, 2'b10, 32'h0, 32'h8, 32'h0, 32'hDEAD);
        chk("lit_raw_wgnt", 64'(gs), 64'(2'b10));
        step(2'b01, 2'b00, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0);
        chk("lit_raw_rgnt", 64'(gs), 64'(2'b01));
        idle();
        chk("lit_raw_rsp",   64'(rsp_valid), 64'(2'b01));
        chk("lit_raw_rdata", 64'(rdata),     64'(32'hDEAD));

        // Idle stretch.
        idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            chk($sformatf("lit_idle_we%0d", i),  64'(ram_we),    64'(0));
            chk($sformatf("lit_idle_rsp%0d", i), 64'(rsp_valid), 64'(0));
        end
        chk("lit_idle_rdata_hold", 64'(rdata), 64'(32'hDEAD));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
